button_press_detector: RTL and testbench



---
 rtl/button_press_detector_pkg.sv | 23 ++
 rtl/button_press_detector_if.sv | 22 ++
 rtl/button_press_detector.sv | 61 ++++++
 tb/tb_button_press_detector.sv | 139 +++++++++++++
 4 files changed

// File: rtl/button_press_detector_pkg.sv
// Shared types and constants for the push-button press detector.
package button_press_detector_pkg;

  // Number of consecutive high samples needed to accept a press.
  localparam int DEBOUNCE_DEPTH = 4;

  // FSM state encoding; codes 6 and 7 are unused and recover to WAIT_UP.
  typedef enum logic [2:0] {
    WAIT_UP     = 3'd0,
    BTN_UP      = 3'd1,
    DEBOUNCE_1  = 3'd2,
    DEBOUNCE_2  = 3'd3,
    DEBOUNCE_3  = 3'd4,
    BTN_PRESSED = 3'd5
  } state_e;

  // Last debounce state: the one whose high sample completes the press.
  // DEBOUNCE_1 holds the first high sample, so the last one sits
  // DEBOUNCE_DEPTH - 2 codes above it.
  localparam state_e LAST_DEBOUNCE =
    state_e'(3'(int'(DEBOUNCE_1) + DEBOUNCE_DEPTH - 2));

endpackage : button_press_detector_pkg

// File: rtl/button_press_detector_if.sv
// Button / consumer signal bundle for the press detector.
interface button_press_detector_if;

  logic buttonDown;  // synchronised button level, 1 = pressed
  logic ackPress;    // consumer acknowledge, level-sampled
  logic wasPressed;  // latched press flag

  // Driver side: the button source and the consumer.
  modport master (
    output buttonDown,
    output ackPress,
    input  wasPressed
  );

  // Detector side.
  modport slave (
    input  buttonDown,
    input  ackPress,
    output wasPressed
  );

endinterface : button_press_detector_if

// File: rtl/button_press_detector.sv
// Debounces a synchronised button level and latches one press flag per
// physical press, held until acknowledged; re-arms only after release.
module button_press_detector
  import button_press_detector_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  button_press_detector_if.slave   bus
);

  state_e state_q;
  state_e state_d;

  // State register; asynchronous active-low reset lands in WAIT_UP so a
  // button held through reset is never reported.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_UP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: debounce the button, hold the flag until ack.
  // NOTE: state_d gets a default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_UP: begin
        if (!bus.buttonDown) state_d = BTN_UP;
      end
      BTN_UP: begin
        if (bus.buttonDown) state_d = DEBOUNCE_1;
      end
      DEBOUNCE_1, DEBOUNCE_2, DEBOUNCE_3: begin
        if (!bus.buttonDown) begin
          // Any low sample throws away partial progress.
          state_d = BTN_UP;
        end else if (state_q == LAST_DEBOUNCE) begin
          state_d = BTN_PRESSED;
        end else begin
          state_d = state_e'(state_q + 3'd1);
        end
      end
      BTN_PRESSED: begin
        // Release alone never clears the flag; only the consumer does.
        if (bus.ackPress) state_d = WAIT_UP;
      end
      default: begin
        state_d = WAIT_UP;
      end
    endcase
  end

  // Moore output: pure decode of the state register.
  assign bus.wasPressed = (state_q == BTN_PRESSED);

endmodule : button_press_detector

// File: tb/tb_button_press_detector.sv
// Directed self-checking bench for button_press_detector.
module tb_button_press_detector;
  import button_press_detector_pkg::*;

  logic clock;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  button_press_detector_if bus ();

  button_press_detector dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Checks the state register and the flag together.
  task automatic expect_state(input string tag, input state_e s,
                              input logic wp);
    check({tag, ".state"}, 32'(dut.state_q), 32'(s));
    check({tag, ".wasPressed"}, 32'(bus.wasPressed), 32'(wp));
  endtask

  // Apply inputs, take one rising edge, settle just after it.
  task automatic tick(input logic bd, input logic ack);
    bus.buttonDown = bd;
    bus.ackPress   = ack;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    reset          = 1'b0;
    bus.buttonDown = 1'b1;
    bus.ackPress   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expect_state("reset", WAIT_UP, 1'b0);

    // Button held through reset release is not reported.
    @(negedge clock);
    reset = 1'b1;
    tick(1'b1, 1'b0); expect_state("held_thru_reset", WAIT_UP, 1'b0);
    tick(1'b0, 1'b0); expect_state("rearm0", BTN_UP, 1'b0);

    // Long press.
    tick(1'b1, 1'b0); expect_state("long.e1", DEBOUNCE_1, 1'b0);
    tick(1'b1, 1'b0); expect_state("long.e2", DEBOUNCE_2, 1'b0);
    tick(1'b1, 1'b0); expect_state("long.e3", DEBOUNCE_3, 1'b0);
    tick(1'b1, 1'b0); expect_state("long.e4", BTN_PRESSED, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    expect_state("long.hold", BTN_PRESSED, 1'b1);
    tick(1'b1, 1'b1); expect_state("long.ack", WAIT_UP, 1'b0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    expect_state("long.still_held", WAIT_UP, 1'b0);
    tick(1'b0, 1'b0); expect_state("long.release", BTN_UP, 1'b0);

    // Short press: release does not clear, ack with release on same edge.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    expect_state("short.pressed", BTN_PRESSED, 1'b1);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    expect_state("short.released", BTN_PRESSED, 1'b1);
    tick(1'b0, 1'b1); expect_state("short.ack", WAIT_UP, 1'b0);
    tick(1'b0, 1'b0); expect_state("short.rearm", BTN_UP, 1'b0);

    // Bounces of 3, 2 and 1 high samples.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    expect_state("bounce3.high", DEBOUNCE_3, 1'b0);
    tick(1'b0, 1'b0); expect_state("bounce3.low", BTN_UP, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    expect_state("bounce2.high", DEBOUNCE_2, 1'b0);
    tick(1'b0, 1'b0); expect_state("bounce2.low", BTN_UP, 1'b0);
    tick(1'b1, 1'b0); expect_state("bounce1.high", DEBOUNCE_1, 1'b0);
    tick(1'b0, 1'b0); expect_state("bounce1.low", BTN_UP, 1'b0);

    // Spurious acks outside BTN_PRESSED.
    tick(1'b0, 1'b1); expect_state("sack.btn_up", BTN_UP, 1'b0);
    tick(1'b1, 1'b1); expect_state("sack.d1", DEBOUNCE_1, 1'b0);
    tick(1'b1, 1'b1); expect_state("sack.d2", DEBOUNCE_2, 1'b0);
    tick(1'b1, 1'b1); expect_state("sack.d3", DEBOUNCE_3, 1'b0);
    tick(1'b1, 1'b0); expect_state("sack.pressed", BTN_PRESSED, 1'b1);
    tick(1'b1, 1'b1); expect_state("sack.real_ack", WAIT_UP, 1'b0);
    tick(1'b1, 1'b1); expect_state("sack.wait_up", WAIT_UP, 1'b0);
    tick(1'b0, 1'b1); expect_state("sack.rearm", BTN_UP, 1'b0);

    // Asynchronous reset mid-debounce, then in BTN_PRESSED.
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    expect_state("rst_mid.pre", DEBOUNCE_2, 1'b0);
    reset = 1'b0;
    #1;
    expect_state("rst_mid.async", WAIT_UP, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    tick(1'b0, 1'b0); expect_state("rst_mid.rearm", BTN_UP, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    expect_state("rst_pr.pre", BTN_PRESSED, 1'b1);
    reset = 1'b0;
    #1;
    expect_state("rst_pr.async", WAIT_UP, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Illegal codes recover to WAIT_UP on the next edge.
    @(negedge clock);
    force dut.state_q = state_e'(3'd6);
    #1;
    release dut.state_q;
    check("illegal6.state", 32'(dut.state_q), 32'd6);
    check("illegal6.wasPressed", 32'(bus.wasPressed), 32'd0);
    tick(1'b1, 1'b0); expect_state("illegal6.next", WAIT_UP, 1'b0);
    @(negedge clock);
    force dut.state_q = state_e'(3'd7);
    #1;
    release dut.state_q;
    check("illegal7.wasPressed", 32'(bus.wasPressed), 32'd0);
    tick(1'b1, 1'b0); expect_state("illegal7.next", WAIT_UP, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_button_press_detector
